// File: rtl/sys_bus_fabric.sv
// Address-decoded system-bus fabric: routes core sys_* accesses to NSLV slave windows
// with a ready handshake, timeout abort and bus-error reporting.
module sys_bus_fabric #(
    parameter int          NSLV      = 4,
    parameter int          DW        = 32,
    parameter logic [31:0] BASE      = 32'h0001_0000,
    parameter int          SLOT_BITS = 12,
    parameter int          TMO       = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          sys_w_addr,
    input  logic [31:0]          sys_r_addr,
    input  logic [DW-1:0]        sys_w_line,
    input  logic                 sys_write,
    input  logic                 sys_read,
    output logic [DW-1:0]        sys_r_line,
    output logic                 sys_busy,
    output logic                 sys_error,
    output logic [SLOT_BITS-1:0] s_addr,
    output logic [DW-1:0]        s_w_line,
    output logic [NSLV-1:0]      s_write,
    output logic [NSLV-1:0]      s_read,
    input  logic [NSLV*DW-1:0]   s_r_line,
    input  logic [NSLV-1:0]      s_ready
);

    localparam int              SW       = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int              CW       = $clog2(TMO + 1);
    localparam logic [31:0]     SPAN     = 32'(NSLV) << SLOT_BITS;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TMO - 1);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    typedef struct packed {
        logic                 hit;
        logic [SW-1:0]        slot;
        logic [SLOT_BITS-1:0] off;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] addr);
        dec_t        d;
        logic [31:0] off;
        off    = addr - BASE;
        d.hit  = (addr >= BASE) && (off < SPAN);
        d.slot = SW'(off >> SLOT_BITS);
        d.off  = off[SLOT_BITS-1:0];
        return d;
    endfunction

    state_t           state, state_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic [SLOT_BITS-1:0] s_addr_d;
    logic [DW-1:0]    s_w_line_d, sys_r_line_d;
    logic             sys_error_d;
    logic             pend_rd, pend_rd_d;
    logic [31:0]      pend_addr, pend_addr_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             defer_err, defer_err_d;

    logic [DW-1:0]    slot_data [NSLV];
    logic             ready;
    dec_t             w_dec, r_dec, p_dec, rd_dec;
    logic             start_rd, prior_err;

    always_comb begin
        for (int k = 0; k < NSLV; k++) slot_data[k] = s_r_line[k*DW +: DW];
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q     <= '0;
            s_addr     <= '0;
            s_w_line   <= '0;
            sys_r_line <= '0;
            sys_error  <= 1'b0;
            pend_rd    <= 1'b0;
            pend_addr  <= '0;
            cnt        <= '0;
            defer_err  <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            s_addr     <= s_addr_d;
            s_w_line   <= s_w_line_d;
            sys_r_line <= sys_r_line_d;
            sys_error  <= sys_error_d;
            pend_rd    <= pend_rd_d;
            pend_addr  <= pend_addr_d;
            cnt        <= cnt_d;
            defer_err  <= defer_err_d;
        end
    end

    // Next-state and datapath decisions.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d      = state;
        slot_d       = slot_q;
        s_addr_d     = s_addr;
        s_w_line_d   = s_w_line;
        sys_r_line_d = sys_r_line;
        sys_error_d  = 1'b0;
        pend_rd_d    = pend_rd;
        pend_addr_d  = pend_addr;
        cnt_d        = cnt;
        defer_err_d  = defer_err;
        w_dec        = decode(sys_w_addr);
        r_dec        = decode(sys_r_addr);
        p_dec        = decode(pend_addr);
        rd_dec       = r_dec;
        start_rd     = 1'b0;
        prior_err    = 1'b0;
        ready        = s_ready[slot_q];

        case (state)
            IDLE: begin
                if (sys_write) begin
                    s_w_line_d = sys_w_line;
                    if (w_dec.hit) begin
                        state_d     = WR;
                        slot_d      = w_dec.slot;
                        s_addr_d    = w_dec.off;
                        cnt_d       = '0;
                        pend_rd_d   = sys_read;
                        pend_addr_d = sys_r_addr;
                    end else begin
                        sys_error_d = 1'b1;
                        start_rd    = sys_read;
                        prior_err   = 1'b1;
                    end
                end else if (sys_read) begin
                    start_rd = 1'b1;
                end
            end
            WR: begin
                if (ready || cnt == CNT_LAST) begin
                    state_d     = IDLE;
                    pend_rd_d   = 1'b0;
                    sys_error_d = !ready;
                    start_rd    = pend_rd;
                    rd_dec      = p_dec;
                    prior_err   = !ready;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            RD: begin
                if (defer_err) begin
                    state_d      = IDLE;
                    defer_err_d  = 1'b0;
                    sys_error_d  = 1'b1;
                    sys_r_line_d = '0;
                end else if (ready) begin
                    state_d      = IDLE;
                    sys_r_line_d = slot_data[slot_q];
                end else if (cnt == CNT_LAST) begin
                    state_d      = IDLE;
                    sys_error_d  = 1'b1;
                    sys_r_line_d = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // An unmapped read whose error would coincide with another failure's pulse is
        // parked in RD for one strobe-less cycle so the two pulses stay separate.
        if (start_rd) begin
            if (rd_dec.hit) begin
                state_d     = RD;
                slot_d      = rd_dec.slot;
                s_addr_d    = rd_dec.off;
                cnt_d       = '0;
                defer_err_d = 1'b0;
            end else if (prior_err) begin
                state_d     = RD;
                defer_err_d = 1'b1;
            end else begin
                sys_error_d  = 1'b1;
                sys_r_line_d = '0;
            end
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        s_write  = (state == WR) ? (NSLV'(1) << slot_q) : '0;
        s_read   = (state == RD && !defer_err) ? (NSLV'(1) << slot_q) : '0;
        sys_busy = (state != IDLE);
    end

endmodule
